// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and default constants for the FIFO write arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_MAX_BURST = 4;

  // Depth of the downstream FIFO, for benches that model the full flag.
  localparam int FIFO_DEPTH = 32;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer/FIFO-side signal bundle of the write arbiter.
interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = DEF_DATA_W
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      fifo_full;
  logic                      fifo_wr;
  logic [DATA_W-1:0]         fifo_data;
  logic [NUM_REQ-1:0]        grant;
  logic                      busy;

  // Environment side: producers plus the FIFO's full flag.
  modport master (
    output req_valid, req_data, fifo_full,
    input  req_ready, fifo_wr, fifo_data, grant, busy
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_data, fifo_full,
    output req_ready, fifo_wr, fifo_data, grant, busy
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational rotating priority encoder: first set bit of req at or after
// start, wrapping modulo NUM_REQ.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IW      = $clog2(DEF_NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      start,
  output logic               found,
  output logic [IW-1:0]      index
);

  logic [IW-1:0] pos;

  // Scan from the farthest offset back to start so the nearest hit wins last.
  always_comb begin
    found = 1'b0;
    index = '0;
    pos   = '0;
    for (int unsigned i = 0; i < unsigned'(NUM_REQ); i++) begin
      pos = IW'((int'(start) + NUM_REQ - 1 - int'(i)) % NUM_REQ);
      if (req[pos]) begin
        found = 1'b1;
        index = pos;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers,
// with bursts of up to MAX_BURST beats and zero-bubble handoff.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic             clock,
  input  logic             rst,
  fifo_wr_arbiter_if.slave bus
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST) + 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_REQ - 1);

  state_t        state, state_nx;
  logic [IW-1:0] owner, owner_nx;
  logic [IW-1:0] rr_ptr, rr_ptr_nx;
  logic [CW-1:0] beat_cnt, beat_cnt_nx;

  logic [IW-1:0] owner_inc;
  logic [IW-1:0] pick_start;
  logic [IW-1:0] pick_idx;
  logic [IW-1:0] pick_inc;
  logic          pick_found;
  logic          in_burst;
  logic          owner_valid;
  logic          xfer;
  logic          burst_end;

  assign in_burst    = (state == BURST);
  assign owner_valid = bus.req_valid[owner];
  assign xfer        = rst & in_burst & owner_valid & ~bus.fifo_full;
  assign owner_inc   = (owner == LAST_IDX) ? '0 : owner + 1'b1;
  assign pick_inc    = (pick_idx == LAST_IDX) ? '0 : pick_idx + 1'b1;
  // Full only stalls; a burst ends on its last transfer or a dropped valid.
  assign burst_end   = in_burst & (~owner_valid | (xfer & (beat_cnt == LAST_BEAT)));

  // One encoder serves both cases: at burst end the scan starts just past the
  // owner (equal to rr_ptr in practice) so the ending owner ranks last.
  assign pick_start  = in_burst ? owner_inc : rr_ptr;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_pick (
    .req   (bus.req_valid),
    .start (pick_start),
    .found (pick_found),
    .index (pick_idx)
  );

  assign bus.busy = in_burst;

  // Port-side outputs decoded from the registered owner; gated off in reset.
  always_comb begin
    bus.req_ready = '0;
    bus.grant     = '0;
    bus.fifo_data = '0;
    bus.fifo_wr   = xfer;
    if (in_burst) begin
      bus.fifo_data = bus.req_data[int'(owner)*DATA_W +: DATA_W];
    end
    if (rst && in_burst) begin
      bus.grant[owner] = 1'b1;
      if (!bus.fifo_full) begin
        bus.req_ready[owner] = 1'b1;
      end
    end
  end

  // Next-state: grant from IDLE, count beats, re-arbitrate at burst end.
  always_comb begin
    state_nx    = state;
    owner_nx    = owner;
    rr_ptr_nx   = rr_ptr;
    beat_cnt_nx = beat_cnt;
    unique case (state)
      IDLE: begin
        if (pick_found) begin
          state_nx    = BURST;
          owner_nx    = pick_idx;
          rr_ptr_nx   = pick_inc;
          beat_cnt_nx = '0;
        end
      end
      BURST: begin
        if (burst_end) begin
          if (pick_found) begin
            owner_nx    = pick_idx;
            rr_ptr_nx   = pick_inc;
            beat_cnt_nx = '0;
          end else begin
            state_nx = IDLE;
          end
        end else if (xfer) begin
          beat_cnt_nx = beat_cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!rst) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nx;
      owner    <= owner_nx;
      rr_ptr   <= rr_ptr_nx;
      beat_cnt <= beat_cnt_nx;
    end
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write arbiter that shares one 8-bit FIFO write port among NUM_REQ producers.
- Each producer uses a valid/ready handshake.
- The arbiter drives the FIFO's wr/data_in and observes its full flag.
- The granted producer holds the port for a burst of up to MAX_BURST beats, then rotates.
- Sits directly in front of the 32-deep FIFO; one write per clock maximum.

Parameters:
- NUM_REQ, 4, number of producers (2..8).
- DATA_W, 8, data width; matches FIFO data_in.
- MAX_BURST, 4, max consecutive accepted beats per grant (1..16).

Ports:
- clock, in, 1, rising-edge clock.
- rst, in, 1, synchronous reset, active-low (0 = reset).
- req_valid, in, NUM_REQ, per-producer data valid.
- req_data, in, NUM_REQ*DATA_W, packed producer data; producer i at [i*DATA_W +: DATA_W].
- req_ready, out, NUM_REQ, per-producer accept.
- fifo_full, in, 1, FIFO full flag.
- fifo_wr, out, 1, FIFO write strobe.
- fifo_data, out, DATA_W, FIFO write data.
- grant, out, NUM_REQ, one-hot current owner; 0 when idle.
- busy, out, 1, state == BURST.

Behaviour:
- Registered state: state {IDLE, BURST}, owner (clog2(NUM_REQ) bits), rr_ptr, beat_cnt (clog2(MAX_BURST)+1 bits).
- Reset (rst=0 at posedge): state=IDLE, owner=0, rr_ptr=0, beat_cnt=0.
- While rst=0, fifo_wr, req_ready and grant are forced to 0 combinationally. A reset during a burst abandons it; no partial beat is written.
- Combinational outputs from registered state:
  - req_ready[i] = rst & BURST & owner==i & ~fifo_full.
  - fifo_wr = rst & BURST & req_valid[owner] & ~fifo_full.
  - fifo_data = req_data[owner] when BURST, else 0.
  - grant = one-hot(owner) when BURST.
- Transfer = req_valid[i] & req_ready[i]; exactly one transfer per fifo_wr.
- Round-robin pick: scan req_valid starting at rr_ptr, wrapping mod NUM_REQ; the first set bit wins. On any grant to k, next rr_ptr = (k+1) mod NUM_REQ.
- IDLE:
  - If any req_valid: owner <= pick, beat_cnt <= 0, state <= BURST.
  - Arbitration latency is 1 cycle; the first beat can transfer the cycle after the request is seen.
- BURST, with the owner still valid:
  - Transfer with beat_cnt == MAX_BURST-1: burst ends.
  - Transfer otherwise: beat_cnt++ and stay.
  - fifo_full=1: stall. beat_cnt holds, owner keeps the grant, and full never ends a burst.
- BURST, owner req_valid=0: burst ends this cycle with no transfer.
- Burst end (zero-bubble handoff):
  - Re-arbitrate in the same cycle using the current req_valid with rr_ptr = owner+1, so the ending owner has lowest priority.
  - If the pick is valid: next state BURST, new owner, beat_cnt <= 0. Otherwise IDLE.
  - With a single continuous requester: it is re-granted back-to-back, so writes run every cycle.
- data ordering: beats from one producer reach the FIFO in the order presented; no reordering or duplication.
- A producer may drop req_valid at any time. Data must be held stable while valid & ~ready; the arbiter does not buffer.

Decomposition:
- Shared package fifo_arb_pkg holds:
  - typedef state_t {IDLE, BURST}.
  - Default constants: DATA_W=8, NUM_REQ=4, MAX_BURST=4.
  - FIFO_DEPTH=32, for benches computing full.
- One sub-module: rr_pick, a combinational rotating priority encoder.
  - Inputs: req vector, start pointer.
  - Outputs: found, index.
  - Reused for both IDLE grant and burst-end handoff.

Test Plan:
- Reset: rst=0 for 2 cycles with req_valid=4'b1111 -> fifo_wr=0, grant=0, busy=0. After rst=1, the first grant goes to req 0 one cycle later.
- Single burst: req 2 valid continuously with data 0x10,0x11,… -> IDLE cycle, then 4 writes 0x10–0x13. Immediate re-grant to req 2 with no bubble; 0x14 written next cycle.
- Rotation: all 4 valid continuously -> grant order 0,1,2,3,0, 4 beats each. fifo_wr high every cycle after the first; 16 consecutive writes, tagged data in order.
- Full stall: req 1 mid-burst after 2 beats, fifo_full=1 for 3 cycles -> fifo_wr=0 and req_ready=0 during stall, grant stays req 1, beat_cnt held. After full drops, exactly 2 more beats, then handoff.
- Early release: req 3 owner drops valid after 1 beat while req 0 valid -> that cycle has no write. Next cycle grant=req 0; rr_ptr=1 after its grant.
- Reset mid-burst: rst=0 on the 3rd beat of req 1's burst -> no fifo_wr that cycle. After release, state IDLE and rr_ptr=0; the next grant goes to the lowest-index valid requester.
